ps2_key_detect: RTL and testbench
=================================

# ps2_key_detect

Upstream input stage for the reaction-benchmark display FSM. Receives PS/2 keyboard frames on the raw `PS2_CLK`/`PS2_DAT` pins and decodes make, break and extended prefixes. It drives a clean, registered `keyPress` level that is high exactly while the configured key is held. Raw scan codes and error pulses are exported for debug LEDs/HEX displays.

## Interface
- `TARGET_CODE`, 8'h29: make code of the tracked key (space bar, set 2).
- `TIMEOUT_CYCLES`, 50000: `clk` cycles allowed between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- `clk`  input  1  system clock (50 MHz).
- `iReset`  input  1  asynchronous, active-high reset.
- `PS2_CLK`  input  1  raw keyboard clock, asynchronous to `clk`.
- `PS2_DAT`  input  1  raw keyboard data, asynchronous to `clk`.
- `keyPress`  output  1  level, high while `TARGET_CODE` is held.
- `scanCode`  output  8  last correctly received byte, including prefixes.
- `codeValid`  output  1  one-cycle pulse when `scanCode` updates.
- `frameError`  output  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Synchronise `PS2_CLK` and `PS2_DAT` through two flops each. `fall` = previous synced clock 1 and current synced clock 0.
- All receive actions occur only on cycles with `fall`=1. Data is sampled from the synced `PS2_DAT`.
- Receive FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: if the data bit is 0 (start bit) → DATA and clear the bit counter. If it is 1, stay in IDLE with no error.
  - DATA: shift in LSB first, 8 bits; after the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: require stop bit = 1 and odd parity (parity bit = ~^data) → good byte. Otherwise pulse `frameError`. Always → IDLE.
- Timeout:
  - A 16-bit counter clears on every `fall` and while in IDLE, and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES-1` outside IDLE: pulse `frameError`, clear the partial byte and go → IDLE.
  - A `fall` in the same cycle takes priority, i.e. no timeout.
- Decoder flags `brk` and `ext` act only on good bytes:
  - 8'hF0: set `brk`; `keyPress` unchanged.
  - 8'hE0: set `ext`; `keyPress` unchanged.
  - Any other byte: if it equals `TARGET_CODE` and `ext`=0, set `keyPress` = ~`brk`. Then clear both flags.
  - Typematic repeats of the make code leave `keyPress`=1.
- Every good byte (prefixes included) loads `scanCode` and pulses `codeValid`.
- Any `frameError` clears `brk` and `ext`; `keyPress` holds its value.
- Reset: all outputs 0, FSM in IDLE, flags, counters and synchronisers cleared. An asserted reset mid-frame discards the partial frame. After release, reception restarts at the next start bit.

## Timing
- Latency: a `PS2_CLK` pin fall before `clk` edge 0 makes `fall`=1 during cycle 2. The resulting outputs (`scanCode`, `codeValid`, `frameError`, `keyPress`) are registered and visible from edge 3.
- `codeValid` and `frameError` are each high exactly one cycle per event and never in the same cycle.
- `keyPress` changes in the same cycle that `codeValid` pulses for the decisive byte.
- PS/2 clock period is 60–100 µs (≥3000 `clk` cycles), so no two `fall` events are closer than 3 cycles.
- Output `keyPress` is glitch-free, being a single flop output. It is safe for the display FSM to sample directly.

## Test plan
- Frame 8'h29 (parity 0, stop 1) → `codeValid` one cycle, `scanCode`=8'h29, `keyPress`=1 from 3 cycles after the stop-bit fall.
- Sequence 29, 29, F0, 29 → `keyPress` stays 1 through the repeat and falls to 0 on the last byte. There are four `codeValid` pulses and the final `scanCode`=8'h29.
- With `keyPress`=1, send E0 29 then E0 F0 29 → `keyPress` stays 1, both flags clear after each 29, five `codeValid` pulses.
- Frame 8'h29 with parity bit 1 → `frameError` one cycle, no `codeValid`, `scanCode` and `keyPress` unchanged. The next good 8'h29 is accepted normally.
- Stop the clock after 4 data bits, wait `TIMEOUT_CYCLES` → single `frameError` pulse, FSM back in IDLE. A following full F0 frame produces `scanCode`=8'hF0.
- Assert `iReset` asynchronously mid-frame with `keyPress`=1 → `keyPress`, `codeValid` and `frameError` go to 0 immediately, with no pulses afterwards. The next complete frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_detect_if.sv
// Raw PS/2 pins plus the decoded key outputs, shared by the keyboard side (master)
// and the decoder (slave).
interface ps2_key_detect_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       keyPress;
  logic [7:0] scanCode;
  logic       codeValid;
  logic       frameError;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  keyPress, scanCode, codeValid, frameError
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output keyPress, scanCode, codeValid, frameError
  );
endinterface

// File: rtl/ps2_key_detect.sv
// PS/2 frame receiver and make/break decoder that drives a clean keyPress level
// for one configured key, plus raw scan codes and error pulses for debug.
module ps2_key_detect #(
  parameter logic [7:0] TARGET_CODE    = 8'h29,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            iReset,
  ps2_key_detect_if.slave ps2
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxState_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  BREAK_CODE   = 8'hF0;
  localparam logic [7:0]  EXT_CODE     = 8'hE0;

  logic [1:0]  clkSync;
  logic [1:0]  datSync;
  logic        clkPrev;
  logic        fall;
  logic        bitIn;

  rxState_t    state;
  rxState_t    stateNext;
  logic [2:0]  bitCnt;
  logic [2:0]  bitCntNext;
  logic [7:0]  shiftReg;
  logic [7:0]  shiftNext;
  logic        parityBit;
  logic        parityNext;
  logic [15:0] timeoutCnt;
  logic [15:0] timeoutNext;
  logic        goodByte;
  logic        errNext;

  logic        brk;
  logic        brkNext;
  logic        ext;
  logic        extNext;
  logic        keyReg;
  logic        keyNext;
  logic [7:0]  scanReg;
  logic [7:0]  scanNext;
  logic        validReg;
  logic        errReg;

  // The falling-edge strobe and its data bit are registered so the receiver sees
  // one aligned, single-cycle event per keyboard clock edge.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      clkSync <= '0;
      datSync <= '0;
      clkPrev <= 1'b0;
      fall    <= 1'b0;
      bitIn   <= 1'b0;
    end else begin
      clkSync <= {clkSync[0], ps2.PS2_CLK};
      datSync <= {datSync[0], ps2.PS2_DAT};
      clkPrev <= clkSync[1];
      fall    <= clkPrev & ~clkSync[1];
      bitIn   <= datSync[1];
    end
  end

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state      <= IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
      timeoutCnt <= '0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      keyReg     <= 1'b0;
      scanReg    <= '0;
      validReg   <= 1'b0;
      errReg     <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      shiftReg   <= shiftNext;
      parityBit  <= parityNext;
      timeoutCnt <= timeoutNext;
      brk        <= brkNext;
      ext        <= extNext;
      keyReg     <= keyNext;
      scanReg    <= scanNext;
      validReg   <= goodByte;
      errReg     <= errNext;
    end
  end

  // A keyboard edge always wins over an expiring timeout in the same cycle.
  always_comb begin
    stateNext   = state;
    bitCntNext  = bitCnt;
    shiftNext   = shiftReg;
    parityNext  = parityBit;
    timeoutNext = timeoutCnt + 16'd1;
    goodByte    = 1'b0;
    errNext     = 1'b0;

    if (state == IDLE || fall) begin
      timeoutNext = '0;
    end

    if (fall) begin
      case (state)
        IDLE: begin
          if (!bitIn) begin
            stateNext  = DATA;
            bitCntNext = '0;
          end
        end
        DATA: begin
          shiftNext  = {bitIn, shiftReg[7:1]};
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            stateNext = PARITY;
          end
        end
        PARITY: begin
          parityNext = bitIn;
          stateNext  = STOP;
        end
        STOP: begin
          stateNext = IDLE;
          if (bitIn && (parityBit == ~^shiftReg)) begin
            goodByte = 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end else if (state != IDLE && timeoutCnt == TIMEOUT_LAST) begin
      errNext    = 1'b1;
      stateNext  = IDLE;
      shiftNext  = '0;
      bitCntNext = '0;
    end
  end

  // Prefix flags only qualify the next ordinary byte; any error forgets them.
  always_comb begin
    keyNext  = keyReg;
    brkNext  = brk;
    extNext  = ext;
    scanNext = scanReg;

    if (goodByte) begin
      scanNext = shiftReg;
      if (shiftReg == BREAK_CODE) begin
        brkNext = 1'b1;
      end else if (shiftReg == EXT_CODE) begin
        extNext = 1'b1;
      end else begin
        if (shiftReg == TARGET_CODE && !ext) begin
          keyNext = ~brk;
        end
        brkNext = 1'b0;
        extNext = 1'b0;
      end
    end else if (errNext) begin
      brkNext = 1'b0;
      extNext = 1'b0;
    end
  end

  assign ps2.keyPress   = keyReg;
  assign ps2.scanCode   = scanReg;
  assign ps2.codeValid  = validReg;
  assign ps2.frameError = errReg;

endmodule

// File: tb/tb_ps2_key_detect.sv
// Drives PS/2 frames into ps2_key_detect and compares every cycle against a
// frame-level model of the keyboard protocol and key decoder.
module tb_ps2_key_detect;
  localparam int         TMO = 200;
  localparam logic [7:0] TGT = 8'h29;

  logic clk    = 1'b0;
  logic iReset = 1'b1;

  ps2_key_detect_if ps2if ();

  ps2_key_detect #(
    .TARGET_CODE   (TGT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .iReset(iReset),
    .ps2   (ps2if.slave)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  bit started = 1'b0;
  int cvCount = 0;
  int feCount = 0;

  // Reference model: pin history, bits collected so far in the frame, decoder flags.
  logic [4:0] hClk = '1;
  logic [4:0] hDat = '1;
  int         cyc = 0;
  int         lastFall = 0;
  int         nb = 0;
  logic [7:0] mData = '0;
  logic [7:0] mScan = '0;
  logic       mPar = 1'b0;
  logic       mBrk = 1'b0;
  logic       mExt = 1'b0;
  logic       mKey = 1'b0;
  logic       mCv = 1'b0;
  logic       mFe = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic badPar, input logic stopBit,
                               input int nBits);
    logic [10:0] frame;
    frame = {stopBit, (~^d) ^ badPar, d, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      ps2if.PS2_DAT = frame[i];
      repeat ($urandom_range(2, 5)) @(negedge clk);
      ps2if.PS2_CLK = 1'b0;
      repeat ($urandom_range(2, 5)) @(negedge clk);
      ps2if.PS2_CLK = 1'b1;
    end
    repeat (6) @(negedge clk);
    #2;
  endtask

  // A pin fall seen at edge j takes effect on the outputs at edge j+3.
  initial forever begin
    @(posedge clk or posedge iReset);
    if (iReset) begin
      hClk = '1;
      hDat = '1;
      nb   = 0;
      mBrk = 1'b0;
      mExt = 1'b0;
      mKey = 1'b0;
      mScan = '0;
      mCv  = 1'b0;
      mFe  = 1'b0;
    end else begin
      hClk = {hClk[3:0], ps2if.PS2_CLK};
      hDat = {hDat[3:0], ps2if.PS2_DAT};
      mCv = 1'b0;
      mFe = 1'b0;
      if (hClk[4] && !hClk[3]) begin
        lastFall = cyc;
        if (nb == 0) begin
          if (!hDat[3]) nb = 1;
        end else if (nb <= 8) begin
          mData[3'(nb - 1)] = hDat[3];
          nb++;
        end else if (nb == 9) begin
          mPar = hDat[3];
          nb = 10;
        end else begin
          nb = 0;
          if (hDat[3] && ($countones({mData, mPar}) % 2 == 1)) begin
            mScan = mData;
            mCv = 1'b1;
            if (mData == 8'hF0) mBrk = 1'b1;
            else if (mData == 8'hE0) mExt = 1'b1;
            else begin
              if (mData == TGT && !mExt) mKey = !mBrk;
              mBrk = 1'b0;
              mExt = 1'b0;
            end
          end else begin
            mFe = 1'b1;
            mBrk = 1'b0;
            mExt = 1'b0;
          end
        end
      end else if (nb != 0 && cyc - lastFall == TMO) begin
        nb = 0;
        mFe = 1'b1;
        mBrk = 1'b0;
        mExt = 1'b0;
      end
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      checkOutput("outputs{kp,sc,cv,fe}",
                  32'({ps2if.keyPress, ps2if.scanCode, ps2if.codeValid, ps2if.frameError}),
                  32'({mKey, mScan, mCv, mFe}));
      if (ps2if.codeValid === 1'b1) cvCount++;
      if (ps2if.frameError === 1'b1) feCount++;
    end
  end

  initial begin
    int cv0;
    int fe0;
    ps2if.PS2_CLK = 1'b1;
    ps2if.PS2_DAT = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset keyPress", 32'(ps2if.keyPress), 32'd0);
    checkOutput("reset scanCode", 32'(ps2if.scanCode), 32'd0);
    checkOutput("reset codeValid", 32'(ps2if.codeValid), 32'd0);
    checkOutput("reset frameError", 32'(ps2if.frameError), 32'd0);
    started = 1'b1;
    iReset = 1'b0;
    repeat (5) @(negedge clk);
    #2;

    $display("[TB] latency of a single space-bar make code");
    applyStimulus(8'h29, 1'b0, 1'b1, 10);
    ps2if.PS2_DAT = 1'b1;
    repeat (3) @(negedge clk);
    ps2if.PS2_CLK = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("latency kp before edge 3", 32'(ps2if.keyPress), 32'd0);
    checkOutput("latency cv before edge 3", 32'(ps2if.codeValid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latency kp at edge 3", 32'(ps2if.keyPress), 32'd1);
    checkOutput("latency cv at edge 3", 32'(ps2if.codeValid), 32'd1);
    checkOutput("latency sc at edge 3", 32'(ps2if.scanCode), 32'h29);
    @(posedge clk);
    #1;
    checkOutput("latency cv one cycle", 32'(ps2if.codeValid), 32'd0);
    @(negedge clk);
    ps2if.PS2_CLK = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checkOutput("model kp after make", 32'(mKey), 32'd1);

    $display("[TB] make, repeat, break");
    cv0 = cvCount;
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    checkOutput("kp held across F0", 32'(ps2if.keyPress), 32'd1);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("kp after break", 32'(ps2if.keyPress), 32'd0);
    checkOutput("sc after break", 32'(ps2if.scanCode), 32'h29);
    checkOutput("cv pulses make/break", 32'(cvCount - cv0), 32'd4);

    $display("[TB] extended codes do not touch the key");
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    cv0 = cvCount;
    applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("kp after E0 29", 32'(ps2if.keyPress), 32'd1);
    checkOutput("model flags after E0 29", 32'({mBrk, mExt}), 32'd0);
    applyStimulus(8'hE0, 1'b0, 1'b1, 11);
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("kp after E0 F0 29", 32'(ps2if.keyPress), 32'd1);
    checkOutput("model flags after E0 F0 29", 32'({mBrk, mExt}), 32'd0);
    checkOutput("cv pulses extended", 32'(cvCount - cv0), 32'd5);
    checkOutput("sc after extended", 32'(ps2if.scanCode), 32'h29);

    $display("[TB] parity error clears a pending break");
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    checkOutput("sc after F0", 32'(ps2if.scanCode), 32'hF0);
    cv0 = cvCount;
    fe0 = feCount;
    applyStimulus(8'h29, 1'b1, 1'b1, 11);
    checkOutput("fe pulses parity", 32'(feCount - fe0), 32'd1);
    checkOutput("cv pulses parity", 32'(cvCount - cv0), 32'd0);
    checkOutput("sc held on parity error", 32'(ps2if.scanCode), 32'hF0);
    checkOutput("kp held on parity error", 32'(ps2if.keyPress), 32'd1);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("kp after error then 29", 32'(ps2if.keyPress), 32'd1);

    $display("[TB] timeout mid-frame");
    fe0 = feCount;
    applyStimulus(8'h29, 1'b0, 1'b1, 5);
    repeat (TMO + 10) @(negedge clk);
    #2;
    checkOutput("fe pulses timeout", 32'(feCount - fe0), 32'd1);
    checkOutput("model idle after timeout", 32'(nb), 32'd0);
    applyStimulus(8'hF0, 1'b0, 1'b1, 11);
    checkOutput("sc F0 after timeout", 32'(ps2if.scanCode), 32'hF0);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("kp break after timeout", 32'(ps2if.keyPress), 32'd0);

    $display("[TB] asynchronous reset mid-frame");
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("kp before reset", 32'(ps2if.keyPress), 32'd1);
    applyStimulus(8'h55, 1'b0, 1'b1, 5);
    @(posedge clk);
    #3;
    iReset = 1'b1;
    #1;
    checkOutput("kp at reset", 32'(ps2if.keyPress), 32'd0);
    checkOutput("cv at reset", 32'(ps2if.codeValid), 32'd0);
    checkOutput("fe at reset", 32'(ps2if.frameError), 32'd0);
    checkOutput("sc at reset", 32'(ps2if.scanCode), 32'd0);
    ps2if.PS2_CLK = 1'b1;
    ps2if.PS2_DAT = 1'b1;
    cv0 = cvCount;
    fe0 = feCount;
    repeat (8) @(negedge clk);
    iReset = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    checkOutput("no pulses after reset", 32'((cvCount - cv0) + (feCount - fe0)), 32'd0);
    applyStimulus(8'h29, 1'b0, 1'b1, 11);
    checkOutput("kp after reset frame", 32'(ps2if.keyPress), 32'd1);
    checkOutput("sc after reset frame", 32'(ps2if.scanCode), 32'h29);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      int r;
      int nBits;
      logic [7:0] d;
      logic bp;
      logic sb;
      r = $urandom_range(0, 99);
      if (r < 35) d = TGT;
      else if (r < 55) d = 8'hF0;
      else if (r < 70) d = 8'hE0;
      else d = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 99) < 8);
      sb = ($urandom_range(0, 99) >= 4);
      nBits = ($urandom_range(0, 99) < 6) ? $urandom_range(1, 10) : 11;
      applyStimulus(d, bp, sb, nBits);
      if (nBits < 11) begin
        repeat ($urandom_range(TMO - 12, TMO + 2)) @(negedge clk);
        #2;
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      #2;
    end
    repeat (TMO + 20) @(negedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
